date_counter: RTL and testbench

//  Calendar stage downstream of the hour counter: consumes its ClkDay level and keeps day/month/year
//  (2000-2099), including month lengths and leap years. Supports +/- editing of each field from the

---
 rtl/date_pkg.sv | 17 +
 rtl/days_in_month.sv | 10 +
 rtl/date_counter.sv | 100 ++++++++++
 tb/tb_date_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// date_pkg: field encodings, edit FSM state/op types and calendar limits for date_counter.
package date_pkg;
  localparam logic [1:0] FLD_DAY   = 2'd0;
  localparam logic [1:0] FLD_MONTH = 2'd1;
  localparam logic [1:0] FLD_YEAR  = 2'd2;
  localparam logic [4:0] DAY_MIN   = 5'd1;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [6:0] YEAR_MAX  = 7'd99;
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ARMED = 1'b1;
  // dir: 1 = plus, 0 = minus
  typedef struct packed {
    logic [1:0] field;
    logic       dir;
  } op_t;
endpackage

// File: rtl/days_in_month.sv
// days_in_month: number of days in a month (1..12), February follows leap.
module days_in_month (
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] len
);
  always_comb
    len = (month == 4'd2) ? (leap ? 5'd29 : 5'd28) :
          (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
endmodule

// File: rtl/date_counter.sv
// date_counter: day/month/year (2000-2099) advanced at midnight, with front-panel +/- editing.
// Leap-year support is compiled in with DATE_LEAP_EN.
module date_counter
  import date_pkg::*;
#(
  parameter logic [6:0] YEAR_RST    = 7'd0,
  parameter logic [1:0] DATE_SCREEN = 2'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ClkDay,
  input  logic       KeyPlus,
  input  logic       KeyMinus,
  input  logic       EditMode,
  input  logic [2:0] EditPos,
  input  logic [1:0] screen,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       leap
);
  logic [4:0] r_day;
  logic [3:0] r_month;
  logic [6:0] r_year;
  logic       r_clkday_q;
  state_t     r_state;
  op_t        r_op;
  logic       w_leap, w_ed_leap, w_fall, w_keys_up, w_arm, w_apply, w_last, w_month_bad;
  logic [4:0] w_len, w_ed_len, w_ed_day;
  logic [3:0] w_ed_month;
  logic [6:0] w_ed_year;

`ifdef DATE_LEAP_EN
  assign w_leap    = (r_year[1:0] == 2'd0);
  assign w_ed_leap = (w_ed_year[1:0] == 2'd0);
`else
  assign w_leap    = 1'b0;
  assign w_ed_leap = 1'b0;
`endif

  days_in_month u_len_cur (.month(r_month),    .leap(w_leap),    .len(w_len));
  days_in_month u_len_ed  (.month(w_ed_month), .leap(w_ed_leap), .len(w_ed_len));

  assign w_fall      = r_clkday_q & ~ClkDay;
  assign w_keys_up   = KeyPlus & KeyMinus;
  assign w_arm       = (r_state == ST_IDLE) & EditMode & (screen == DATE_SCREEN) &
                       (EditPos <= 3'd2) & ~w_keys_up;
  assign w_apply     = (r_state == ST_ARMED) & EditMode & w_keys_up;
  assign w_last      = (r_day >= w_len);
  assign w_month_bad = (r_month == 4'd0) | (r_month > MONTH_MAX);

  // Each field wraps on its own; the day is clamped afterwards against the edited month/year.
  always_comb begin
    w_ed_day   = r_day;
    w_ed_month = r_month;
    w_ed_year  = r_year;
    if (r_op.field == FLD_DAY)
      w_ed_day = r_op.dir ? (r_day >= w_len ? DAY_MIN : r_day + 5'd1)
                          : (r_day <= DAY_MIN ? w_len : r_day - 5'd1);
    if (r_op.field == FLD_MONTH)
      w_ed_month = r_op.dir ? (r_month >= MONTH_MAX ? 4'd1 : r_month + 4'd1)
                            : (r_month <= 4'd1 ? MONTH_MAX : r_month - 4'd1);
    if (r_op.field == FLD_YEAR)
      w_ed_year = r_op.dir ? (r_year >= YEAR_MAX ? 7'd0 : r_year + 7'd1)
                           : (r_year == 7'd0 ? YEAR_MAX : r_year - 7'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_day      <= DAY_MIN;
      r_month    <= 4'd1;
      r_year     <= YEAR_RST;
      r_clkday_q <= 1'b0;
      r_state    <= ST_IDLE;
      r_op       <= '0;
    end else begin
      r_clkday_q <= ClkDay;
      if (!EditMode && w_fall) begin
        r_day <= w_last ? DAY_MIN : r_day + 5'd1;
        if (w_last) r_month <= (r_month >= MONTH_MAX) ? 4'd1 : r_month + 4'd1;
        if (w_last && r_month >= MONTH_MAX) r_year <= (r_year >= YEAR_MAX) ? 7'd0 : r_year + 7'd1;
      end else if (w_apply) begin
        r_day   <= (w_ed_day > w_ed_len) ? w_ed_len : w_ed_day;
        r_month <= w_ed_month;
        r_year  <= w_ed_year;
      end else if (!EditMode && (r_day > w_len || w_month_bad)) begin
        r_day <= (r_day > w_len) ? w_len : r_day;
        if (w_month_bad) r_month <= 4'd1;
      end
      r_state <= w_arm ? ST_ARMED :
                 (r_state == ST_ARMED && (!EditMode || w_keys_up)) ? ST_IDLE : r_state;
      if (w_arm) r_op <= '{field: EditPos[1:0], dir: ~KeyPlus};
    end
  end

  assign day   = r_day;
  assign month = r_month;
  assign year  = r_year;
  assign leap  = w_leap;
endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: table vectors, hand-written corner sequences and random transactions vs a calendar model.
module tb_date_counter;
  logic       clk = 1'b0, reset = 1'b0, ClkDay = 1'b0, KeyPlus = 1'b1, KeyMinus = 1'b1, EditMode = 1'b0;
  logic [2:0] EditPos = 3'd0;
  logic [1:0] screen = 2'd0;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       leap;
  int checks = 0, errors = 0;
  int md = 1, mm = 1, my = 0;
`ifdef DATE_LEAP_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif
  localparam int MDAYS [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  typedef struct {
    int kind;
    int pos;
    int plus;
    int ed, em, ey;
  } vec_t;

  date_counter dut (
    .clk(clk), .reset(reset), .ClkDay(ClkDay), .KeyPlus(KeyPlus), .KeyMinus(KeyMinus),
    .EditMode(EditMode), .EditPos(EditPos), .screen(screen),
    .day(day), .month(month), .year(year), .leap(leap)
  );

  always #5 clk = ~clk;

  function automatic bit is_leap(int y);
    return LEAP_EN && (y % 4 == 0);
  endfunction

  function automatic int mlen(int m, int y);
    return MDAYS[m-1] + ((m == 2 && is_leap(y)) ? 1 : 0);
  endfunction

  task automatic chk(input string name);
    checks++;
    if (day !== 5'(md) || month !== 4'(mm) || year !== 7'(my) || leap !== is_leap(my)) begin
      errors++;
      $display("FAIL %s: got %0d-%0d-%0d leap %0b, want %0d-%0d-%0d leap %0b",
               name, day, month, year, leap, md, mm, my, is_leap(my));
    end
  endtask

  task automatic expect_date(input int d, input int m, input int y);
    md = d; mm = m; my = y;
  endtask

  task automatic m_adv();
    if (md < mlen(mm, my)) md++;
    else begin
      md = 1;
      if (mm == 12) begin mm = 1; my = (my + 1) % 100; end
      else mm++;
    end
  endtask

  task automatic m_edit(input int pos, input bit plus);
    if (pos == 0) md = plus ? (md % mlen(mm, my)) + 1 : (md == 1 ? mlen(mm, my) : md - 1);
    if (pos == 1) mm = plus ? (mm % 12) + 1 : (mm == 1 ? 12 : mm - 1);
    if (pos == 2) my = plus ? (my + 1) % 100 : (my + 99) % 100;
    if (md > mlen(mm, my)) md = mlen(mm, my);
  endtask

  task automatic press(input int pos, input bit p, input bit m, input int hold, input int scr);
    @(negedge clk);
    EditMode = 1'b1; screen = 2'(scr); EditPos = 3'(pos);
    KeyPlus = !p; KeyMinus = !m;
    repeat (hold) @(negedge clk);
    KeyPlus = 1'b1; KeyMinus = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic midnight(input bit em, input int hold);
    @(negedge clk);
    EditMode = em; ClkDay = 1'b1;
    repeat (hold) @(negedge clk);
    ClkDay = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drop_while_armed(input int pos);
    @(negedge clk);
    EditMode = 1'b1; screen = 2'd1; EditPos = 3'(pos); KeyPlus = 1'b0;
    repeat (2) @(negedge clk);
    EditMode = 1'b0;
    @(negedge clk);
    KeyPlus = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t tbl [12];
    tbl[0]  = '{0, 0, 0, 31,  1,  0};
    tbl[1]  = '{1, 0, 0,  1,  2,  0};
    tbl[2]  = '{0, 2, 0,  1,  2, 99};
    tbl[3]  = '{0, 1, 0,  1,  1, 99};
    tbl[4]  = '{0, 1, 0,  1, 12, 99};
    tbl[5]  = '{0, 0, 0, 31, 12, 99};
    tbl[6]  = '{1, 0, 0,  1,  1,  0};
    tbl[7]  = '{0, 0, 0, 31,  1,  0};
    tbl[8]  = '{0, 0, 1,  1,  1,  0};
    tbl[9]  = '{0, 1, 1,  1,  2,  0};
    tbl[10] = '{0, 1, 1,  1,  3,  0};
    tbl[11] = '{0, 0, 0, 31,  3,  0};

    repeat (3) @(negedge clk);
    chk("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].kind == 0) press(tbl[i].pos, tbl[i].plus != 0, tbl[i].plus == 0, 2, 1);
      else midnight(1'b0, 3);
      expect_date(tbl[i].ed, tbl[i].em, tbl[i].ey);
      chk($sformatf("table_%0d", i));
    end

    // 31 Mar 2000 minus month clamps into February
    press(1, 0, 1, 3, 1);
    expect_date(LEAP_EN ? 29 : 28, 2, 0);
    chk("mar31_minus_month");
    if (LEAP_EN) press(0, 0, 1, 1, 1);
    expect_date(28, 2, 0);
    chk("feb28_2000");
    midnight(1'b0, 2);
    m_adv();
    chk("feb28_fall_2000");
    if (LEAP_EN) begin
      midnight(1'b0, 2);
      m_adv();
    end
    expect_date(1, 3, 0);
    chk("mar1_2000");
    press(2, 1, 0, 1, 1);
    press(1, 0, 1, 1, 1);
    press(0, 0, 1, 1, 1);
    expect_date(28, 2, 1);
    chk("feb28_2001");
    midnight(1'b0, 2);
    expect_date(1, 3, 1);
    chk("feb28_fall_2001");

    @(negedge clk);
    EditMode = 1'b0; ClkDay = 1'b1;
    repeat (100) @(negedge clk);
    chk("clkday_high_100");
    ClkDay = 1'b0;
    @(negedge clk);
    expect_date(2, 3, 1);
    chk("clkday_fall_after_hold");

    @(negedge clk);
    EditMode = 1'b1; screen = 2'd1; EditPos = 3'd2; KeyPlus = 1'b0;
    repeat (50) @(negedge clk);
    chk("plus_held_50");
    KeyPlus = 1'b1;
    repeat (2) @(negedge clk);
    expect_date(2, 3, 2);
    chk("plus_release_one_step");
    repeat (3) press(2, 0, 1, 1, 1);
    expect_date(2, 3, 99);
    chk("year_99");
    press(2, 1, 1, 3, 1);
    expect_date(2, 3, 0);
    chk("both_keys_plus_wins");

    drop_while_armed(0);
    chk("editmode_drop_discard");
    midnight(1'b1, 3);
    chk("fall_in_edit_ignored");
    press(0, 1, 0, 2, 0);
    chk("wrong_screen_ignored");
    press(5, 1, 0, 2, 1);
    chk("bad_pos_ignored");

    @(negedge clk);
    EditMode = 1'b1; screen = 2'd1; EditPos = 3'd1; KeyMinus = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    expect_date(1, 1, 0);
    chk("reset_mid_press");
    @(negedge clk);
    KeyMinus = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("release_after_reset");

    for (int n = 0; n < 150; n++) begin
      int kind, pos, keys;
      kind = $urandom_range(0, 5);
      pos  = $urandom_range(0, 2);
      keys = $urandom_range(1, 3);
      case (kind)
        0, 1: begin midnight(1'b0, $urandom_range(1, 4)); m_adv(); end
        2: begin press(pos, keys != 2, keys != 1, $urandom_range(1, 6), 1); m_edit(pos, keys != 2); end
        3: midnight(1'b1, $urandom_range(1, 4));
        4: if ($urandom_range(0, 1) == 1) press($urandom_range(3, 7), 1, 0, 2, 1);
           else press(pos, 0, 1, 2, 2 * $urandom_range(0, 1));
        default: drop_while_armed(pos);
      endcase
      chk($sformatf("random_%0d_kind%0d", n, kind));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
